ifm_out_fsm: RTL and testbench
==============================

# ifm_out_fsm

Read side of the ingress frame buffer. Drains complete frames from the 73-bit data FIFO and the 1-bit frame-status FIFO, both filled by the ingress write FSM, and emits them on a 64-bit AXI4-Stream master. Frames flagged bad by the MAC are discarded or forwarded with `tuser`, per parameter. The block also keeps good/bad frame counters. Sits between the ingress FIFOs and the downstream packet consumer, in the rx_clk domain.

## Interface
- `C_DROP_BAD`, 1, 1: discard frames whose status bit is 1; 0: forward them with `m_axis_tuser`=1 on the last beat
- `C_CNT_W`, 32, width of the frame counters
- `rx_clk`  in  1  clock
- `rx_reset`  in  1  reset, asynchronous, active-high
- `data_fifo_rdata`  in  73  FWFT head word: [63:0] tdata, [71:64] tkeep, [72] tlast
- `data_fifo_empty`  in  1  data FIFO empty
- `data_fifo_rden`  out  1  pop head word
- `info_fifo_rdata`  in  1  FWFT head status: 1 = bad frame
- `info_fifo_empty`  in  1  status FIFO empty
- `info_fifo_rden`  out  1  pop head status
- `m_axis_tdata`  out  64  stream data
- `m_axis_tkeep`  out  8  byte enables
- `m_axis_tlast`  out  1  last beat
- `m_axis_tuser`  out  1  bad-frame marker, valid with tlast
- `m_axis_tvalid`  out  1  beat valid
- `m_axis_tready`  in  1  downstream ready
- `good_frames`  out  C_CNT_W  frames forwarded with tuser=0
- `bad_frames`  out  C_CNT_W  frames with status bit 1 (dropped or flagged)

## Operation
- Both FIFOs are first-word-fall-through: head valid whenever `!empty`; `rden` pops in the same cycle.
- A status entry exists only after the frame's last data word is written. A non-empty status FIFO therefore means a complete frame is in the data FIFO.
- States:
  - S_IDLE: if `!info_fifo_empty`, pulse `info_fifo_rden`, latch `bad = info_fifo_rdata`, go to S_DISCARD if `bad & C_DROP_BAD`, else S_FWD.
  - S_FWD: pop when `!data_fifo_empty` and the output register is free or draining (`!m_axis_tvalid | m_axis_tready`). The popped word loads the output register with `m_axis_tuser = bad & rdata[72]`. Popping the tlast word returns to S_IDLE.
  - S_DISCARD: pop one word per cycle while `!data_fifo_empty`. Nothing is driven to the stream. Popping tlast returns to S_IDLE.
- `data_fifo_empty` inside S_FWD/S_DISCARD: stall with no pop. This covers status/data FIFO visibility skew.
- Output register follows AXI rules:
  - Once `m_axis_tvalid`=1, all m_axis fields stay stable until `m_axis_tready`=1.
  - tvalid never depends combinationally on tready.
- Counters wrap:
  - `good_frames` increments when a tlast beat with tuser=0 is accepted (tvalid & tready).
  - `bad_frames` increments when a tlast beat with tuser=1 is accepted, or when the tlast word is popped in S_DISCARD.
- A frame without tlast (FIFO corruption) is not recovered. The block waits in S_FWD/S_DISCARD until tlast arrives.

## Timing
- Reset values: state S_IDLE; `m_axis_tvalid`, `m_axis_tlast`, `m_axis_tuser`, `data_fifo_rden`, `info_fifo_rden`, both counters all 0; `m_axis_tdata`/`m_axis_tkeep` 0.
- Reset mid-frame aborts immediately. The FIFOs share `rx_reset` and are cleared externally.
- `*_rden` are combinational from state and FIFO flags. The m_axis outputs are registered.
- Latency: status visible at cycle 0 → first beat `m_axis_tvalid` at cycle 2, i.e. S_IDLE pop at 0, S_FWD pop at 1.
- Throughput is 1 beat/cycle within a frame with tready held high. There is 1 idle cycle between frames (the S_IDLE status pop).
- Discard rate is 1 word/cycle, independent of tready.
- Counter update lands 1 cycle after the qualifying event.

## Structure
- `ifm_defs.vh`, shared with the ingress write FSM:
  - data FIFO field offsets: DATA 63:0, KEEP 71:64, LAST 72
  - word width 73
  - state encodings S_IDLE/S_FWD/S_DISCARD
- One sub-module, `ifm_axis_oreg`: a single-stage AXI-Stream output register with load/ready handshake. The FSM and counters stay in `ifm_out_fsm`.

## Test plan
- Good 3-word frame (tlast on word 3, tkeep 8'h0F), tready=1 → 3 consecutive beats starting 2 cycles after status visible; tlast only on beat 3; tuser=0; `good_frames`=1.
- Bad 4-word frame with C_DROP_BAD=1 → 4 pops on consecutive cycles, no m_axis_tvalid, `bad_frames`=1. An immediately following good frame is forwarded intact.
- Bad frame with C_DROP_BAD=0 → forwarded; tuser=1 on the tlast beat only; `bad_frames`=1, `good_frames`=0.
- Random tready, 50% duty, on an 8-word frame → all fields stable while stalled; words in order; no pops while the register is full and tready=0.
- Status visible while `data_fifo_empty`=1 for 2 cycles → no data pop and no tvalid until empty deasserts, then normal delivery.
- Assert rx_reset mid-frame (beat 2 of 5) → all outputs 0 within the reset cycle; state S_IDLE; counters 0. After release, a new frame is forwarded correctly.

Source files
------------

// File: rtl/ifm_out_fsm_pkg.sv
// Shared definitions for the ingress frame buffer: data FIFO word layout and
// read-side FSM state encoding.
package ifm_out_fsm_pkg;

   localparam int unsigned IFM_WORD_W  = 73;
   localparam int unsigned IFM_DATA_LO = 0;
   localparam int unsigned IFM_DATA_HI = 63;
   localparam int unsigned IFM_KEEP_LO = 64;
   localparam int unsigned IFM_KEEP_HI = 71;
   localparam int unsigned IFM_LAST    = 72;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_FWD     = 2'd1,
      S_DISCARD = 2'd2
   } ifm_state_t;

endpackage

// File: rtl/ifm_out_fsm_if.sv
// 64-bit AXI4-Stream link carrying forwarded frames, with a tuser bad-frame
// marker on the last beat.
interface ifm_out_fsm_if;
   import ifm_out_fsm_pkg::*;

   logic [IFM_DATA_HI-IFM_DATA_LO:0] m_axis_tdata;
   logic [IFM_KEEP_HI-IFM_KEEP_LO:0] m_axis_tkeep;
   logic                             m_axis_tlast;
   logic                             m_axis_tuser;
   logic                             m_axis_tvalid;
   logic                             m_axis_tready;

   modport master (
      output m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser, m_axis_tvalid,
      input  m_axis_tready
   );

   modport slave (
      input  m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser, m_axis_tvalid,
      output m_axis_tready
   );

endinterface

// File: rtl/ifm_out_fsm_axis_oreg.sv
// Single-stage AXI-Stream output register. load may only be asserted while
// load_ready is high, so fields never change while a beat is stalled.
module ifm_axis_oreg
   import ifm_out_fsm_pkg::*;
(
   input  logic                             rx_clk,
   input  logic                             rx_reset,
   input  logic                             load,
   input  logic [IFM_DATA_HI-IFM_DATA_LO:0] load_data,
   input  logic [IFM_KEEP_HI-IFM_KEEP_LO:0] load_keep,
   input  logic                             load_last,
   input  logic                             load_user,
   output logic                             load_ready,
   ifm_out_fsm_if.master                    axis
);

   assign load_ready = !axis.m_axis_tvalid || axis.m_axis_tready;

   always_ff @(posedge rx_clk or posedge rx_reset) begin
      if (rx_reset) begin
         axis.m_axis_tvalid <= 1'b0;
         axis.m_axis_tdata  <= '0;
         axis.m_axis_tkeep  <= '0;
         axis.m_axis_tlast  <= 1'b0;
         axis.m_axis_tuser  <= 1'b0;
      end else if (load) begin
         axis.m_axis_tvalid <= 1'b1;
         axis.m_axis_tdata  <= load_data;
         axis.m_axis_tkeep  <= load_keep;
         axis.m_axis_tlast  <= load_last;
         axis.m_axis_tuser  <= load_user;
      end else if (axis.m_axis_tready) begin
         axis.m_axis_tvalid <= 1'b0;
      end
   end

endmodule

// File: rtl/ifm_out_fsm.sv
// Read side of the ingress frame buffer: drains complete frames from the data
// and status FIFOs onto AXI-Stream, dropping or flagging bad frames.
module ifm_out_fsm
   import ifm_out_fsm_pkg::*;
#(
   parameter bit          C_DROP_BAD = 1'b1,
   parameter int unsigned C_CNT_W    = 32
) (
   input  logic                  rx_clk,
   input  logic                  rx_reset,
   input  logic [IFM_WORD_W-1:0] data_fifo_rdata,
   input  logic                  data_fifo_empty,
   output logic                  data_fifo_rden,
   input  logic                  info_fifo_rdata,
   input  logic                  info_fifo_empty,
   output logic                  info_fifo_rden,
   ifm_out_fsm_if.master         axis,
   output logic [C_CNT_W-1:0]    good_frames,
   output logic [C_CNT_W-1:0]    bad_frames
);

   ifm_state_t state, state_nxt;
   logic       bad;
   logic       can_load;
   logic       head_last;
   logic       load;
   logic       accept_last;
   logic       good_inc;
   logic       bad_inc;

   assign head_last = data_fifo_rdata[IFM_LAST];

   always_ff @(posedge rx_clk or posedge rx_reset) begin
      if (rx_reset) begin
         state <= S_IDLE;
         bad   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (info_fifo_rden)
            bad <= info_fifo_rdata;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:
            if (!info_fifo_empty)
               state_nxt = (info_fifo_rdata && C_DROP_BAD) ? S_DISCARD : S_FWD;
         S_FWD, S_DISCARD:
            if (data_fifo_rden && head_last)
               state_nxt = S_IDLE;
         default:
            state_nxt = S_IDLE;
      endcase
   end

   // Pops are gated by reset so the FIFO strobes read 0 for the whole reset.
   always_comb begin
      info_fifo_rden = 1'b0;
      data_fifo_rden = 1'b0;
      if (!rx_reset) begin
         unique case (state)
            S_IDLE:    info_fifo_rden = !info_fifo_empty;
            S_FWD:     data_fifo_rden = !data_fifo_empty && can_load;
            S_DISCARD: data_fifo_rden = !data_fifo_empty;
            default:   ;
         endcase
      end
   end

   assign load = data_fifo_rden && (state == S_FWD);

   ifm_axis_oreg u_oreg (
      .rx_clk     (rx_clk),
      .rx_reset   (rx_reset),
      .load       (load),
      .load_data  (data_fifo_rdata[IFM_DATA_HI:IFM_DATA_LO]),
      .load_keep  (data_fifo_rdata[IFM_KEEP_HI:IFM_KEEP_LO]),
      .load_last  (head_last),
      .load_user  (bad && head_last),
      .load_ready (can_load),
      .axis       (axis)
   );

   assign accept_last = axis.m_axis_tvalid && axis.m_axis_tready && axis.m_axis_tlast;
   assign good_inc    = accept_last && !axis.m_axis_tuser;
   assign bad_inc     = (accept_last && axis.m_axis_tuser) ||
                        ((state == S_DISCARD) && data_fifo_rden && head_last);

   always_ff @(posedge rx_clk or posedge rx_reset) begin
      if (rx_reset) begin
         good_frames <= '0;
         bad_frames  <= '0;
      end else begin
         if (good_inc)
            good_frames <= good_frames + C_CNT_W'(1);
         if (bad_inc)
            bad_frames <= bad_frames + C_CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_ifm_out_fsm.sv
// Bench for ifm_out_fsm: a dropping and a forwarding instance share stimulus,
// each fed by its own FWFT FIFO model and checked against an expected-beat queue.
module tb_ifm_out_fsm;
   import ifm_out_fsm_pkg::*;

   typedef struct {
      int unsigned n;
      logic        bad;
      logic [7:0]  lkeep;
      logic        rnd;
      int unsigned skew;
      logic [31:0] exp_good;
      logic [31:0] exp_bad;
   } frame_vec_t;

   logic rx_clk = 1'b0;
   logic rx_reset;
   always #5 rx_clk = ~rx_clk;

   logic [1:0][72:0] d_rdata;
   logic [1:0]       d_empty, d_rden, i_rdata, i_empty, i_rden;
   logic [1:0][31:0] good, badc;
   logic             tready;
   logic [1:0][63:0] tdata;
   logic [1:0][7:0]  tkeep;
   logic [1:0]       tlast, tuser, tvalid;

   ifm_out_fsm_if ax0 ();
   ifm_out_fsm_if ax1 ();

   assign ax0.m_axis_tready = tready;
   assign ax1.m_axis_tready = tready;
   assign tdata[0] = ax0.m_axis_tdata;  assign tdata[1] = ax1.m_axis_tdata;
   assign tkeep[0] = ax0.m_axis_tkeep;  assign tkeep[1] = ax1.m_axis_tkeep;
   assign tlast[0] = ax0.m_axis_tlast;  assign tlast[1] = ax1.m_axis_tlast;
   assign tuser[0] = ax0.m_axis_tuser;  assign tuser[1] = ax1.m_axis_tuser;
   assign tvalid[0] = ax0.m_axis_tvalid; assign tvalid[1] = ax1.m_axis_tvalid;

   ifm_out_fsm #(.C_DROP_BAD(1'b1), .C_CNT_W(32)) dut_drop (
      .rx_clk(rx_clk), .rx_reset(rx_reset),
      .data_fifo_rdata(d_rdata[0]), .data_fifo_empty(d_empty[0]), .data_fifo_rden(d_rden[0]),
      .info_fifo_rdata(i_rdata[0]), .info_fifo_empty(i_empty[0]), .info_fifo_rden(i_rden[0]),
      .axis(ax0.master), .good_frames(good[0]), .bad_frames(badc[0])
   );

   ifm_out_fsm #(.C_DROP_BAD(1'b0), .C_CNT_W(32)) dut_fwd (
      .rx_clk(rx_clk), .rx_reset(rx_reset),
      .data_fifo_rdata(d_rdata[1]), .data_fifo_empty(d_empty[1]), .data_fifo_rden(d_rden[1]),
      .info_fifo_rdata(i_rdata[1]), .info_fifo_empty(i_empty[1]), .info_fifo_rden(i_rden[1]),
      .axis(ax1.master), .good_frames(good[1]), .bad_frames(badc[1])
   );

   logic [72:0] dq [2][$];
   logic        iq [2][$];
   logic [73:0] eq [2][$];
   logic        fdrop [2][$];

   int          vectors = 0;
   int          miscompares = 0;
   int          mgood [2];
   int          mbad [2];
   logic        rnd_mode = 1'b0;
   logic [1:0]  smp_drden, smp_iren, smp_valid;
   logic [1:0]  hold_v = '0;
   logic [74:0] held [2];
   frame_vec_t  vecs [8];

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive_fifos();
      for (int s = 0; s < 2; s++) begin
         d_empty[s] = (dq[s].size() == 0);
         d_rdata[s] = d_empty[s] ? '0 : dq[s][0];
         i_empty[s] = (iq[s].size() == 0);
         i_rdata[s] = i_empty[s] ? 1'b0 : iq[s][0];
      end
   endtask

   // Samples one cycle mid-period, then advances the FIFO models past the edge.
   task automatic tick();
      logic [73:0] eb;
      logic        dropped;
      @(negedge rx_clk);
      for (int s = 0; s < 2; s++) begin
         smp_drden[s] = d_rden[s];
         smp_iren[s]  = i_rden[s];
         smp_valid[s] = tvalid[s];
         if (hold_v[s])
            chk($sformatf("stall_stable_dut%0d", s),
                {tvalid[s], tuser[s], tlast[s], tkeep[s], tdata[s]}, held[s]);
         if (tvalid[s] && tready) begin
            if (eq[s].size() == 0) begin
               chk($sformatf("unexpected_beat_dut%0d", s), 1, 0);
            end else begin
               eb = eq[s].pop_front();
               chk($sformatf("beat_dut%0d", s), {tuser[s], tlast[s], tkeep[s], tdata[s]}, eb);
               if (eb[72]) begin
                  if (eb[73]) begin
                     chk($sformatf("bad_cnt_pre_dut%0d", s), badc[s], mbad[s]);
                     mbad[s]++;
                  end else begin
                     chk($sformatf("good_cnt_pre_dut%0d", s), good[s], mgood[s]);
                     mgood[s]++;
                  end
               end
            end
         end
         if (s == 1 && tvalid[s] && !tready)
            chk("pop_while_full_dut1", d_rden[s], 0);
         hold_v[s] = tvalid[s] && !tready;
         held[s]   = {tvalid[s], tuser[s], tlast[s], tkeep[s], tdata[s]};
         if (d_rden[s]) begin
            chk($sformatf("pop_on_empty_dut%0d", s), d_empty[s], 0);
            if (dq[s].size() > 0 && dq[s][0][72] && fdrop[s].size() > 0) begin
               dropped = fdrop[s].pop_front();
               if (dropped) begin
                  chk($sformatf("drop_cnt_pre_dut%0d", s), badc[s], mbad[s]);
                  mbad[s]++;
               end
            end
         end
      end
      @(posedge rx_clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         if (smp_drden[s] && dq[s].size() > 0) void'(dq[s].pop_front());
         if (smp_iren[s] && iq[s].size() > 0) void'(iq[s].pop_front());
      end
      if (rnd_mode) tready = 1'($urandom_range(0, 1));
      drive_fifos();
   endtask

   task automatic run_frame(input int unsigned f, input frame_vec_t v);
      logic [72:0] words [$];
      logic [72:0] w;
      logic        drop, lw, fwd, exp_pop;
      logic        done = 1'b0;
      int unsigned first, dstart;
      dstart   = (v.skew > 1) ? v.skew : 1;
      first    = (v.skew + 1 > 2) ? v.skew + 1 : 2;
      rnd_mode = v.rnd;
      tready   = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int unsigned i = 0; i < v.n; i++) begin
         lw = (i == v.n - 1);
         w  = {lw, lw ? v.lkeep : 8'hFF, 32'h0000_1000 + 32'(f), 32'hC0DE_0000 + 32'(i)};
         words.push_back(w);
      end
      for (int s = 0; s < 2; s++) begin
         drop = v.bad && (s == 0);
         fdrop[s].push_back(drop);
         iq[s].push_back(v.bad);
         if (!drop)
            foreach (words[i]) eq[s].push_back({v.bad && words[i][72], words[i]});
      end
      drive_fifos();
      for (int unsigned c = 0; c < 200 && !done; c++) begin
         if (c == v.skew) begin
            for (int s = 0; s < 2; s++) foreach (words[i]) dq[s].push_back(words[i]);
            drive_fifos();
         end
         tick();
         for (int s = 0; s < 2; s++) begin
            fwd = !(v.bad && s == 0);
            if (c == 0) chk($sformatf("status_pop_dut%0d", s), smp_iren[s], 1);
            if (c == 1) chk($sformatf("status_single_pop_dut%0d", s), smp_iren[s], 0);
            if (fwd && c < dstart) chk($sformatf("no_early_pop_dut%0d", s), smp_drden[s], 0);
            if (fwd && !v.rnd && c <= first + v.n)
               chk($sformatf("valid_c%0d_dut%0d", c, s), smp_valid[s],
                   (c >= first && c < first + v.n) ? 1 : 0);
            if (!fwd) begin
               exp_pop = (c >= dstart && c < dstart + v.n);
               chk($sformatf("discard_pop_c%0d", c), smp_drden[s], exp_pop);
               chk($sformatf("discard_novalid_c%0d", c), smp_valid[s], 0);
            end
         end
         done = 1'b1;
         for (int s = 0; s < 2; s++)
            if (dq[s].size() != 0 || iq[s].size() != 0 || eq[s].size() != 0 || hold_v[s])
               done = 1'b0;
      end
      if (!done) chk($sformatf("frame%0d_timeout", f), 0, 1);
      for (int s = 0; s < 2; s++) begin
         chk($sformatf("good_frames_f%0d_dut%0d", f, s), good[s], v.exp_good);
         chk($sformatf("bad_frames_f%0d_dut%0d", f, s), badc[s], v.exp_bad);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      frame_vec_t rv;
      logic [72:0] w;
      //          n  bad  lkeep  rnd skew good bad
      vecs[0] = '{3, 1'b0, 8'h0F, 1'b0, 0, 32'd1, 32'd0};
      vecs[1] = '{4, 1'b1, 8'hFF, 1'b0, 0, 32'd1, 32'd1};
      vecs[2] = '{2, 1'b0, 8'h01, 1'b0, 0, 32'd2, 32'd1};
      vecs[3] = '{8, 1'b0, 8'hFF, 1'b1, 0, 32'd3, 32'd1};
      vecs[4] = '{5, 1'b1, 8'h3F, 1'b1, 0, 32'd3, 32'd2};
      vecs[5] = '{3, 1'b0, 8'h07, 1'b0, 2, 32'd4, 32'd2};
      vecs[6] = '{1, 1'b0, 8'h80, 1'b0, 0, 32'd5, 32'd2};
      vecs[7] = '{1, 1'b1, 8'hFF, 1'b0, 0, 32'd5, 32'd3};

      for (int s = 0; s < 2; s++) begin mgood[s] = 0; mbad[s] = 0; end
      rx_reset = 1'b1;
      tready   = 1'b0;
      drive_fifos();
      repeat (2) @(posedge rx_clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         chk($sformatf("rst_tvalid_dut%0d", s), tvalid[s], 0);
         chk($sformatf("rst_fields_dut%0d", s), {tuser[s], tlast[s], tkeep[s], tdata[s]}, 0);
         chk($sformatf("rst_rden_dut%0d", s), {d_rden[s], i_rden[s]}, 0);
         chk($sformatf("rst_cnt_dut%0d", s), {good[s], badc[s]}, 0);
      end
      @(negedge rx_clk) rx_reset = 1'b0;
      @(posedge rx_clk);
      #1;

      for (int unsigned f = 0; f < 8; f++) run_frame(f, vecs[f]);

      // Reset while beat 2 of a 5-word frame is presented.
      tready   = 1'b1;
      rnd_mode = 1'b0;
      for (int s = 0; s < 2; s++) begin
         for (int unsigned i = 0; i < 5; i++) begin
            w = {i == 4, 8'hFF, 32'h0000_2000, 32'hC0DE_0000 + 32'(i)};
            dq[s].push_back(w);
            eq[s].push_back({1'b0, w});
         end
         iq[s].push_back(1'b0);
         fdrop[s].push_back(1'b0);
      end
      drive_fifos();
      repeat (3) tick();
      for (int s = 0; s < 2; s++)
         chk($sformatf("pre_reset_beat2_dut%0d", s), {tvalid[s], tdata[s]}, {1'b1, 64'h0000_2000_C0DE_0001});
      #2 rx_reset = 1'b1;
      #1;
      for (int s = 0; s < 2; s++) begin
         chk($sformatf("midrst_tvalid_dut%0d", s), tvalid[s], 0);
         chk($sformatf("midrst_fields_dut%0d", s), {tuser[s], tlast[s], tkeep[s], tdata[s]}, 0);
         chk($sformatf("midrst_rden_dut%0d", s), {d_rden[s], i_rden[s]}, 0);
         chk($sformatf("midrst_cnt_dut%0d", s), {good[s], badc[s]}, 0);
         dq[s].delete(); iq[s].delete(); eq[s].delete(); fdrop[s].delete();
         mgood[s] = 0; mbad[s] = 0;
      end
      hold_v = '0;
      drive_fifos();
      @(posedge rx_clk);
      @(negedge rx_clk) rx_reset = 1'b0;
      @(posedge rx_clk);
      #1;
      rv = '{2, 1'b0, 8'h03, 1'b0, 0, 32'd1, 32'd0};
      run_frame(20, rv);
      rv = '{2, 1'b1, 8'hFF, 1'b0, 0, 32'd1, 32'd1};
      run_frame(21, rv);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
